tile_result_packetizer: RTL
===========================

// Module: tile_result_packetizer
// PURPOSE
// - Egress stage between PE-array accumulator outputs and the local injection port of the tile NoC router.
// - Buffers ACC_W-bit accumulator results and packs them two per flit.
// - On a command, emits one packet: one HEAD flit (dest, src, word count), then BODY flits, ending in a TAIL flit.
// - Full valid/ready on every interface; one flit/cycle sustained when the FIFO holds data.
// PARAMETERS
// - NOC_FLIT_W  64  flit width; fixed layout below requires 64
// - ACC_W       24  accumulator word width; two words per payload flit
// - FIFO_DEPTH  16  result FIFO entries; power of 2, >=4
// - TILE_ID     0   8-bit source id placed in HEAD flits
// PORTS
// - clk          in   1           clock
// - rst          in   1           synchronous, active-high reset
// - acc_data     in   ACC_W       accumulator result from PE array
// - acc_valid    in   1           acc_data valid
// - acc_ready    out  1           FIFO not full; push when acc_valid&&acc_ready
// - cmd_valid    in   1           packet request
// - cmd_ready    out  1           high only in IDLE
// - cmd_dest     in   8           destination tile id
// - cmd_len      in   8           payload words 0..255
// - flit_out     out  NOC_FLIT_W  flit to router local input
// - valid_out    out  1           flit_out valid
// - ready_in     in   1           router accepts flit
// - busy         out  1           FSM not IDLE
// BEHAVIOUR
// - Reset: flit_out=0, valid_out=0, busy=0, FSM=IDLE, FIFO empty. First cycle after reset: acc_ready=1, cmd_ready=1.
// - Flit layout: [63:62] type (01 HEAD, 00 BODY, 10 TAIL, 11 HEAD_TAIL).
//   - HEAD: [61:54] dest, [53:46] TILE_ID, [45:38] len, rest 0.
//   - Payload: [47:24] word1 (later), [23:0] word0 (earlier), [61:48] 0.
// - FIFO: push on acc_valid&&acc_ready, in any FSM state; words may be banked ahead of a command.
//   - Full with push+pop in the same cycle: push is refused, since acc_ready is combinational from full.
//   - Empty: no bypass; a word is poppable the cycle after its push.
// - Output register: flit_out/valid_out are registered.
//   - Holding rule: while valid_out&&!ready_in, flit_out and valid_out must not change.
//   - The register may reload in the same cycle valid_out&&ready_in fires.
// - FSM states:
//   - IDLE: cmd_valid&&cmd_ready latches dest/len, rem=len.
//     - len==0: go to LAST and load HEAD_TAIL.
//     - else: go to BODY and load HEAD.
//     - HEAD/HEAD_TAIL flit is valid at T+1, where T is the accept cycle.
//   - BODY: when the output register is free/draining, load a flit.
//     - If rem>=2: needs FIFO count>=2; pops 2 words.
//     - If rem==1: needs count>=1; pops 1 word, word1=0.
//     - Type is TAIL when this flit takes rem to 0, else BODY.
//     - After loading TAIL, go to LAST.
//   - LAST: wait until the final flit handshakes, then go to IDLE. cmd_ready rises the cycle after.
// - Starvation: in BODY with insufficient words, valid_out drops after the current flit is accepted. No bubble flit is ever sent.
// - rem is 8-bit and never underflows; a pop never exceeds rem.
// - Reset mid-packet: truncates the packet immediately (valid_out=0, FIFO flushed). The router is reset on the same rst.
// STRUCTURE
// - Package neuraedge_noc_pkg holds:
//   - flit_type_e enum (HEAD/BODY/TAIL/HEAD_TAIL);
//   - field position localparams (TYPE_MSB, DEST_LSB, SRC_LSB, LEN_LSB, W1_LSB);
//   - pack_head() function;
//   - ID_W=8, LEN_W=8.
// - Sub-module tile_result_fifo (DEPTH, W):
//   - sync FIFO with registered read data and pop2 support;
//   - extra-bit wrap pointers;
//   - exposes count, full, empty.
// - FSM and output register live in the top.
// TESTING
// - Reset: hold rst 3 cycles -> valid_out=0, flit_out=0, busy=0. Cycle after release: acc_ready=1, cmd_ready=1.
// - Even packet: dest=0x12, len=4; push 0x000001..0x000004; ready_in=1 -> three flits.
//   - HEAD: type 01, dest 0x12, src TILE_ID, len 4.
//   - BODY: {w1=0x000002, w0=0x000001}.
//   - TAIL: {0x000004, 0x000003}.
//   - busy low after TAIL is accepted.
// - Odd packet: len=3, words 0xA,0xB,0xC -> BODY {0xB,0xA}, TAIL {0x000000,0xC}. Exactly 3 FIFO pops.
// - Backpressure:
//   - ready_in=0 for 5 cycles mid-BODY -> flit_out bit-stable and no pops.
//   - Push 16 words -> acc_ready=0; 17th word held until a pop.
// - Zero length: len=0 -> single HEAD_TAIL flit with len 0. FIFO count unchanged (pre-banked words stay).
// - Starvation + reset: len=6 with only 3 words pushed -> HEAD, BODY, then valid_out=0.
//   - Assert rst -> next cycle IDLE and FIFO empty.
//   - A new len=2 packet then completes correctly.

Source files
------------

// File: rtl/neuraedge_noc_pkg.sv
// Shared NoC flit definitions for the tile egress path.
// Contents: flit type encoding, 64-bit flit field positions, id/length widths,
// and a helper that builds a HEAD / HEAD_TAIL flit.
package neuraedge_noc_pkg;

  localparam int unsigned FLIT_W = 64;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned LEN_W  = 8;

  // Field positions inside a 64-bit flit
  localparam int unsigned TYPE_MSB = 63;
  localparam int unsigned DEST_LSB = 54;
  localparam int unsigned SRC_LSB  = 46;
  localparam int unsigned LEN_LSB  = 38;
  localparam int unsigned W1_LSB   = 24;

  typedef enum logic [1:0] {
    FlitBody     = 2'b00,
    FlitHead     = 2'b01,
    FlitTail     = 2'b10,
    FlitHeadTail = 2'b11
  } flit_type_e;

  function automatic logic [FLIT_W-1:0] pack_head(input flit_type_e       ftype,
                                                  input logic [ID_W-1:0]  dest,
                                                  input logic [ID_W-1:0]  src,
                                                  input logic [LEN_W-1:0] len);
    logic [FLIT_W-1:0] flit;
    flit                         = '0;
    flit[TYPE_MSB -: 2]          = ftype;
    flit[DEST_LSB +: ID_W]       = dest;
    flit[SRC_LSB +: ID_W]        = src;
    flit[LEN_LSB +: LEN_W]       = len;
    return flit;
  endfunction

endpackage

// File: rtl/tile_result_fifo.sv
// Synchronous result FIFO with registered read data and single/double pop.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes contents)
//   i_push, i_wdata   write one word; ignored while full
//   i_pop, i_pop2     pop one word / pop two words (i_pop2 takes priority)
//   o_rdata0/1        oldest and second-oldest words (valid when count covers them)
//   o_count           number of stored words
//   o_full, o_empty   status flags
module tile_result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  input  logic                     i_pop2,
  output logic [W-1:0]             o_rdata0,
  output logic [W-1:0]             o_rdata1,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [W-1:0]  r_rdata0;
  logic [W-1:0]  r_rdata1;

  logic [AW:0]   w_pop_n;
  logic [AW:0]   w_rd_nxt;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx0;
  logic [AW-1:0] w_rd_idx1;
  logic          w_push;

  // Extra MSB distinguishes full from empty when the indices match
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count  = r_wr_ptr - r_rd_ptr;
  assign w_push   = i_push && !o_full;
  assign w_wr_idx = r_wr_ptr[AW-1:0];

  always_comb begin
    w_pop_n = '0;
    if (i_pop2) begin
      w_pop_n = (AW+1)'(2);
    end else if (i_pop) begin
      w_pop_n = (AW+1)'(1);
    end
  end

  assign w_rd_nxt  = r_rd_ptr + w_pop_n;
  assign w_rd_idx0 = w_rd_nxt[AW-1:0];
  assign w_rd_idx1 = w_rd_idx0 + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= i_wdata;
    end
  end

  // Read registers preload the next head words; a word written this cycle into
  // a head slot is forwarded so it is readable the cycle after its push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_rdata0 <= (w_push && (w_wr_idx == w_rd_idx0)) ? i_wdata : r_mem[w_rd_idx0];
      r_rdata1 <= (w_push && (w_wr_idx == w_rd_idx1)) ? i_wdata : r_mem[w_rd_idx1];
    end
  end

  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;

endmodule

// File: rtl/tile_result_packetizer.sv
// Egress packetizer: buffers accumulator results and emits one NoC packet per
// command (HEAD, BODY..., TAIL, or a single HEAD_TAIL for zero length), packing
// two words per payload flit.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   acc_data/acc_valid/acc_ready   accumulator result stream into the FIFO
//   cmd_valid/cmd_ready            packet request, accepted only in IDLE
//   cmd_dest, cmd_len              destination tile id, payload word count
//   flit_out/valid_out/ready_in    registered flit stream to the router
//   busy                           packet in progress
import neuraedge_noc_pkg::*;

module tile_result_packetizer #(
  parameter int unsigned NOC_FLIT_W = 64,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TILE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ACC_W-1:0]      acc_data,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_W-1:0]       cmd_dest,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic [NOC_FLIT_W-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  logic [1:0]            r_state;
  logic [LEN_W-1:0]      r_rem;
  logic [NOC_FLIT_W-1:0] r_flit;
  logic                  r_valid;

  logic [ACC_W-1:0]      w_rdata0;
  logic [ACC_W-1:0]      w_rdata1;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_out_free;
  logic                  w_cmd_fire;
  logic                  w_take2;
  logic                  w_have_words;
  logic                  w_load_body;
  logic                  w_pop1;
  logic                  w_pop2;
  logic [LEN_W-1:0]      w_rem_nxt;
  logic [NOC_FLIT_W-1:0] w_head_flit;
  logic [NOC_FLIT_W-1:0] w_body_flit;

  tile_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ACC_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (acc_valid && acc_ready),
    .i_wdata  (acc_data),
    .i_pop    (w_pop1),
    .i_pop2   (w_pop2),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign acc_ready  = !w_full;
  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign flit_out   = r_flit;
  assign valid_out  = r_valid;

  // Output register may reload when empty or when its current flit is leaving
  assign w_out_free = !r_valid || ready_in;
  assign w_cmd_fire = cmd_valid && cmd_ready;

  assign w_take2      = (r_rem >= LEN_W'(2));
  assign w_have_words = w_take2 ? (w_count >= CNT_W'(2)) : !w_empty;
  assign w_load_body  = (r_state == ST_BODY) && w_out_free && w_have_words;
  assign w_pop2       = w_load_body && w_take2;
  assign w_pop1       = w_load_body && !w_take2;
  assign w_rem_nxt    = r_rem - (w_take2 ? LEN_W'(2) : LEN_W'(1));

  always_comb begin
    flit_type_e ftype;
    ftype = (cmd_len == '0) ? FlitHeadTail : FlitHead;
    w_head_flit = pack_head(ftype, cmd_dest, ID_W'(TILE_ID), cmd_len);
  end

  always_comb begin
    w_body_flit                      = '0;
    w_body_flit[TYPE_MSB -: 2]       = (w_rem_nxt == '0) ? FlitTail : FlitBody;
    w_body_flit[ACC_W-1:0]           = w_rdata0;
    w_body_flit[W1_LSB +: ACC_W]     = w_take2 ? w_rdata1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_flit  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Output register is always empty here: LAST only exits on handshake
          if (w_cmd_fire) begin
            r_rem   <= cmd_len;
            r_flit  <= w_head_flit;
            r_valid <= 1'b1;
            r_state <= (cmd_len == '0) ? ST_LAST : ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_load_body) begin
            r_flit  <= w_body_flit;
            r_valid <= 1'b1;
            r_rem   <= w_rem_nxt;
            if (w_rem_nxt == '0) begin
              r_state <= ST_LAST;
            end
          end else if (w_out_free) begin
            // Starved: let the previous flit go and send nothing in its place
            r_valid <= 1'b0;
          end
        end
        ST_LAST: begin
          if (r_valid && ready_in) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
